// File: rtl/seg7_capture.sv
// Reads back an active-low 7-segment display, waits for the pattern to settle,
// and classifies it as a hex digit, blank, reset-wait glyph or unknown.
module seg7_capture #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 250000,
  parameter int CNT_WIDTH     = 18
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic [6:0] i_Segments_n,
  output logic [3:0] o_Nibble,
  output logic [1:0] o_Code,
  output logic [6:0] o_Segments,
  output logic       o_Valid,
  output logic [7:0] o_Error_Count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [1:0] CODE_DIGIT   = 2'd0;
  localparam logic [1:0] CODE_BLANK   = 2'd1;
  localparam logic [1:0] CODE_WAIT    = 2'd2;
  localparam logic [1:0] CODE_UNKNOWN = 2'd3;

  localparam logic [CNT_WIDTH-1:0] STABLE_CNT = CNT_WIDTH'(STABLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  logic [6:0]             sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] fill_q;
  logic [6:0]             s;
  logic [6:0]             prev_q;
  logic                   prev_vld_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  state_t                 state_q;
  logic                   acc_q;
  logic [3:0]             nib_q;
  logic [1:0]             code_q;
  logic [6:0]             seg_q;
  logic                   valid_q;
  logic [7:0]             err_q;
  logic [1:0]             dec_code_d;
  logic [3:0]             dec_nib_d;

  // fill_q marks when the synchroniser holds real pin samples rather than reset values.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 7'h7F;
      fill_q <= '0;
    end else begin
      sync_q[0] <= i_Segments_n;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign s = ~sync_q[SYNC_STAGES-1];

  always_comb begin
    dec_code_d = CODE_DIGIT;
    dec_nib_d  = 4'h0;
    case (s)
      7'h3F: dec_nib_d = 4'h0;
      7'h06: dec_nib_d = 4'h1;
      7'h5B: dec_nib_d = 4'h2;
      7'h4F: dec_nib_d = 4'h3;
      7'h66: dec_nib_d = 4'h4;
      7'h6D: dec_nib_d = 4'h5;
      7'h7D: dec_nib_d = 4'h6;
      7'h07: dec_nib_d = 4'h7;
      7'h7F: dec_nib_d = 4'h8;
      7'h6F: dec_nib_d = 4'h9;
      7'h77: dec_nib_d = 4'hA;
      7'h7C: dec_nib_d = 4'hB;
      7'h39: dec_nib_d = 4'hC;
      7'h5E: dec_nib_d = 4'hD;
      7'h79: dec_nib_d = 4'hE;
      7'h71: dec_nib_d = 4'hF;
      7'h00: dec_code_d = CODE_BLANK;
      7'h50: dec_code_d = CODE_WAIT;
      default: dec_code_d = CODE_UNKNOWN;
    endcase
  end

  // acc_q clear means nothing has been accepted since reset, so the first accept always reports.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      prev_q     <= 7'h00;
      prev_vld_q <= 1'b0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      acc_q      <= 1'b0;
      nib_q      <= 4'h0;
      code_q     <= CODE_BLANK;
      seg_q      <= 7'h00;
      valid_q    <= 1'b0;
      err_q      <= 8'h00;
    end else begin
      valid_q <= 1'b0;
      if (fill_q[SYNC_STAGES-1]) begin
        if (!prev_vld_q || s != prev_q) begin
          prev_q     <= s;
          prev_vld_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= SETTLE;
        end else if (state_q == SETTLE && cnt_q != STABLE_CNT) begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == STABLE_CNT - CNT_ONE) begin
            state_q <= LOCKED;
            if (!acc_q || s != seg_q) begin
              acc_q   <= 1'b1;
              seg_q   <= s;
              code_q  <= dec_code_d;
              valid_q <= 1'b1;
              if (dec_code_d == CODE_DIGIT) nib_q <= dec_nib_d;
              if (dec_code_d == CODE_UNKNOWN && err_q != 8'hFF) err_q <= err_q + 8'h01;
            end
          end
        end
      end
    end
  end

  assign o_Nibble      = nib_q;
  assign o_Code        = code_q;
  assign o_Segments    = seg_q;
  assign o_Valid       = valid_q;
  assign o_Error_Count = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture with STABLE_CYCLES=8, SYNC_STAGES=2.
module tb_seg7_capture;

  logic       clk;
  logic       rst_n;
  logic [6:0] pins;
  logic [3:0] nibble;
  logic [1:0] code;
  logic [6:0] segs;
  logic       valid;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_capture #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(8),
    .CNT_WIDTH    (4)
  ) dut (
    .i_Clk        (clk),
    .i_Reset_n    (rst_n),
    .i_Segments_n (pins),
    .o_Nibble     (nibble),
    .o_Code       (code),
    .o_Segments   (segs),
    .o_Valid      (valid),
    .o_Error_Count(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] pins;
    int         hold;
    int         pulses;
    int         first;
    logic [3:0] nib;
    logic [1:0] code;
    logic [6:0] segs;
    logic [7:0] err;
  } vec_t;

  vec_t vec [14];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called at a negedge; the new pins are first seen by posedge n=1.
  task automatic apply(input logic [6:0] p, input int hold, output int pulses, output int first);
    pulses = 0;
    first  = 0;
    pins   = p;
    for (int n = 1; n <= hold; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) begin
        pulses++;
        if (first == 0) first = n;
      end
    end
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] nib, input logic [1:0] cd,
                               input logic [6:0] sg, input logic [7:0] er);
    check({tag, " nibble"}, int'(nibble), int'(nib));
    check({tag, " code"}, int'(code), int'(cd));
    check({tag, " segments"}, int'(segs), int'(sg));
    check({tag, " error_count"}, int'(err_cnt), int'(er));
  endtask

  initial begin
    int pulses;
    int first;
    int total;

    vec[0]  = '{7'h7F, 30,  1, 11, 4'h0, 2'd1, 7'h00, 8'd0};
    vec[1]  = '{7'h24, 111, 1, 11, 4'h2, 2'd0, 7'h5B, 8'd0};
    vec[2]  = '{7'h79, 5,   0, 0,  4'h2, 2'd0, 7'h5B, 8'd0};
    vec[3]  = '{7'h24, 20,  0, 0,  4'h2, 2'd0, 7'h5B, 8'd0};
    vec[4]  = '{7'h79, 20,  1, 11, 4'h1, 2'd0, 7'h06, 8'd0};
    vec[5]  = '{7'h2F, 20,  1, 11, 4'h1, 2'd2, 7'h50, 8'd0};
    vec[6]  = '{7'h6D, 20,  1, 11, 4'h1, 2'd3, 7'h12, 8'd1};
    vec[7]  = '{7'h00, 20,  1, 11, 4'h8, 2'd0, 7'h7F, 8'd1};
    vec[8]  = '{7'h08, 20,  1, 11, 4'hA, 2'd0, 7'h77, 8'd1};
    vec[9]  = '{7'h0E, 20,  1, 11, 4'hF, 2'd0, 7'h71, 8'd1};
    vec[10] = '{7'h78, 8,   0, 0,  4'hF, 2'd0, 7'h71, 8'd1};
    vec[11] = '{7'h19, 20,  1, 11, 4'h4, 2'd0, 7'h66, 8'd1};
    vec[12] = '{7'h30, 9,   0, 0,  4'h4, 2'd0, 7'h66, 8'd1};
    vec[13] = '{7'h19, 20,  2, 2,  4'h4, 2'd0, 7'h66, 8'd1};

    rst_n = 1'b0;
    pins  = 7'h7F;
    repeat (3) @(negedge clk);
    check("reset valid", int'(valid), 0);
    check_outputs("reset", 4'h0, 2'd1, 7'h00, 8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      apply(vec[i].pins, vec[i].hold, pulses, first);
      check($sformatf("vec%0d pulses", i), pulses, vec[i].pulses);
      check($sformatf("vec%0d first_pulse_cycle", i), first, vec[i].first);
      check_outputs($sformatf("vec%0d", i), vec[i].nib, vec[i].code, vec[i].segs, vec[i].err);
    end

    // Alternating unknown patterns drive the error counter into saturation.
    total = 0;
    for (int i = 0; i < 300; i++) begin
      apply((i % 2 == 0) ? 7'h5E : 7'h6D, 20, pulses, first);
      total += pulses;
    end
    check("saturate pulses", total, 300);
    check_outputs("saturate", 4'h4, 2'd3, 7'h12, 8'd255);

    // Digit 5 settling; reset lands when the stability counter reads 5.
    apply(7'h12, 8, pulses, first);
    check("pre-reset pulses", pulses, 0);
    rst_n = 1'b0;
    #1;
    check("async reset valid", int'(valid), 0);
    check_outputs("async reset", 4'h0, 2'd1, 7'h00, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(7'h12, 30, pulses, first);
    check("post-reset pulses", pulses, 1);
    check("post-reset first_pulse_cycle", first, 11);
    check_outputs("post-reset", 4'h5, 2'd0, 7'h6D, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
